// File: rtl/coef_calc_if.sv
// Handshake and status bundle between the regression controller and its datapath.
// The controller connects through the master modport and the datapath/environment through the slave modport.
interface coef_calc_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] num_points;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              acc_clr;
    logic              acc_en;
    logic              denom_zero;
    logic              div_start;
    logic              div_done;
    logic              sel_div;
    logic              ld_b1;
    logic              ld_b0;
    logic              busy;
    logic              done;
    logic              err;
    logic [3:0]        con_state;

    modport master (
        input  start, num_points, denom_zero, div_done,
        output rd_en, rd_addr, acc_clr, acc_en, div_start, sel_div,
               ld_b1, ld_b0, busy, done, err, con_state
    );

    modport slave (
        output start, num_points, denom_zero, div_done,
        input  rd_en, rd_addr, acc_clr, acc_en, div_start, sel_div,
               ld_b1, ld_b0, busy, done, err, con_state
    );
endinterface

// File: rtl/coef_calc_ctrl.sv
// Sequencer for a linear-regression coefficient unit: accumulate N points, then run two serial divides.
// Optional divider watchdog is enabled by defining COEF_TIMEOUT_EN.
module coef_calc_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    coef_calc_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CLR   = 4'd1,
        S_READ  = 4'd2,
        S_LAST  = 4'd3,
        S_CHECK = 4'd4,
        S_DIV1  = 4'd5,
        S_WAIT1 = 4'd6,
        S_LDB1  = 4'd7,
        S_DIV0  = 4'd8,
        S_WAIT0 = 4'd9,
        S_LDB0  = 4'd10,
        S_DONE  = 4'd11
    } state_e;

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("coef_calc_ctrl: TIMEOUT_CYC must be nonzero");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic              err_q, err_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              acc_clr_q, acc_clr_d;
    logic              acc_en_q;
    logic              div_start_q, div_start_d;
    logic              sel_div_q, sel_div_d;
    logic              ld_b1_q, ld_b1_d;
    logic              ld_b0_q, ld_b0_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef COEF_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    // Next state, counters and sticky error
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        err_d   = err_q;
`ifdef COEF_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_points != '0) begin
                        n_d     = bus.num_points;
                        err_d   = 1'b0;
                        state_d = S_CLR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CLR: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_READ;
            end
            S_READ: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == n_q - ADDR_W'(1)) state_d = S_LAST;
            end
            S_LAST:  state_d = S_CHECK;
            S_CHECK: begin
                if (bus.denom_zero) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_DIV1;
                end
            end
            S_DIV1, S_DIV0: begin
`ifdef COEF_TIMEOUT_EN
                wd_d = '0;
`endif
                state_d = (state_q == S_DIV1) ? S_WAIT1 : S_WAIT0;
            end
            S_WAIT1, S_WAIT0: begin
                if (bus.div_done) begin
                    state_d = (state_q == S_WAIT1) ? S_LDB1 : S_LDB0;
                end else begin
`ifdef COEF_TIMEOUT_EN
                    // Abandon the run rather than load a stale quotient
                    if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
`endif
                end
            end
            S_LDB1:  state_d = S_DIV0;
            S_LDB0:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered value lines up with con_state
    always_comb begin
        rd_en_d     = (state_d == S_READ);
        rd_addr_d   = rd_en_d ? cnt_d : '0;
        acc_clr_d   = (state_d == S_CLR);
        div_start_d = (state_d == S_DIV1) || (state_d == S_DIV0);
        sel_div_d   = state_d inside {S_DIV0, S_WAIT0, S_LDB0};
        ld_b1_d     = (state_d == S_LDB1);
        ld_b0_d     = (state_d == S_LDB0);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            acc_clr_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            div_start_q <= 1'b0;
            sel_div_q   <= 1'b0;
            ld_b1_q     <= 1'b0;
            ld_b0_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef COEF_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            err_q       <= err_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            acc_clr_q   <= acc_clr_d;
            acc_en_q    <= rd_en_q;
            div_start_q <= div_start_d;
            sel_div_q   <= sel_div_d;
            ld_b1_q     <= ld_b1_d;
            ld_b0_q     <= ld_b0_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef COEF_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.acc_en    = acc_en_q;
    assign bus.div_start = div_start_q;
    assign bus.sel_div   = sel_div_q;
    assign bus.ld_b1     = ld_b1_q;
    assign bus.ld_b0     = ld_b0_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.con_state = 4'(state_q);
endmodule

// File: doc/coef_calc_ctrl.md
COEF_CALC_CTRL -- requirements
Module: coef_calc_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: width of the data-memory address and point count.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64: divider watchdog limit in cycles, used only when COEF_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk, in, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, in, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, in, 1: request a regression run; sampled only in IDLE.
REQ-006 SHALL have port num_points, in, ADDR_W: point count N, latched when start is accepted.
REQ-007 SHALL have ports rd_en, out, 1 and rd_addr, out, ADDR_W: data-memory read; data valid one cycle after rd_en.
REQ-008 SHALL have ports acc_clr, out, 1 and acc_en, out, 1: clear and enable for the Sx/Sy/Sxy/Sxx accumulators.
REQ-009 SHALL have port denom_zero, in, 1: datapath flag (N*Sxx - Sx^2 == 0).
REQ-010 SHALL have ports div_start, out, 1; div_done, in, 1; sel_div, out, 1: serial-divider handshake; sel_div 0 selects the b1 operands, 1 selects the b0 operands.
REQ-011 SHALL have ports ld_b1, out, 1 and ld_b0, out, 1: coefficient register loads.
REQ-012 SHALL have ports busy, out, 1; done, out, 1; err, out, 1; con_state, out, 4: status and debug state.

Function
REQ-013 SHALL have states with con_state encoding: IDLE=0, CLR=1, READ=2, LAST=3, CHECK=4, DIV1=5, WAIT1=6, LDB1=7, DIV0=8, WAIT0=9, LDB0=10, DONE=11.
REQ-014 IDLE: start=1 with num_points!=0 SHALL latch N and go to CLR; start=1 with num_points==0 SHALL go to DONE with err set.
REQ-015 CLR: acc_clr=1 for one cycle; address counter cleared to 0; err cleared; next state READ.
REQ-016 READ: rd_en=1 and rd_addr=counter; counter increments each cycle; when counter==N-1, next state LAST.
REQ-017 acc_en SHALL equal rd_en delayed by one register stage, so every read produces exactly one acc_en pulse.
REQ-018 LAST: no read (drains the final accumulate); next state CHECK.
REQ-019 CHECK: denom_zero=1 SHALL go to DONE with err set; otherwise go to DIV1.
REQ-020 DIV1: div_start=1 for one cycle, sel_div=0; next state WAIT1.
REQ-021 WAIT1: sel_div held at 0; stay until div_done=1, then go to LDB1.
REQ-022 LDB1: ld_b1=1 for one cycle; next state DIV0.
REQ-023 DIV0, WAIT0 and LDB0 SHALL mirror DIV1, WAIT1 and LDB1 with sel_div=1 and ld_b0; LDB0 goes to DONE.
REQ-024 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 err SHALL be sticky until the next accepted start (cleared in CLR).
REQ-027 start while busy SHALL be ignored, and SHALL not be queued.
REQ-028 div_done outside WAIT1 and WAIT0 SHALL be ignored.
REQ-029 N=1: exactly one read is issued; READ is followed directly by LAST.
REQ-030 Counter SHALL never wrap: N=2^ADDR_W-1 reads addresses 0..N-1.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, counter 0, latched N 0, watchdog 0, and all outputs 0 (including err and the acc_en delay stage), even mid-run.
REQ-032 After rst is released, the first accepted start SHALL behave identically to a run from power-up.

Configuration
REQ-033 With macro COEF_TIMEOUT_EN defined, a watchdog SHALL clear on entering WAIT1 or WAIT0 and count each waiting cycle.
REQ-034 With COEF_TIMEOUT_EN defined, reaching TIMEOUT_CYC cycles without div_done SHALL go to DONE with err=1 and no ld_b1 or ld_b0.
REQ-035 Without COEF_TIMEOUT_EN, the watchdog logic SHALL be absent and the WAIT states SHALL wait indefinitely.

Verification
REQ-036 N=4, denom_zero=0, div_done 5 cycles after each div_start -> rd_addr sequence 0,1,2,3; four acc_en pulses; ld_b1 then ld_b0; one done pulse; err=0.
REQ-037 N=3, denom_zero=1 in CHECK -> no div_start; done pulse with err=1; err stays 1 until the next start.
REQ-038 num_points=0 with start -> IDLE to DONE; no rd_en; done=1 and err=1.
REQ-039 rst asserted in WAIT1 -> outputs 0 and con_state=0 within the same cycle; a subsequent N=2 run completes normally.
REQ-040 COEF_TIMEOUT_EN defined, TIMEOUT_CYC=64, div_done never asserted -> DONE 64 cycles after entering WAIT1; err=1; ld_b1 never asserted.
REQ-041 start pulsed during READ and div_done pulsed in READ -> both ignored; the run completes unchanged.
